// File: rtl/fun_arb_pkg.sv
// Shared definitions for the two-requester arbiter in front of one shared function unit.
package fun_arb_pkg;

  localparam int unsigned OP_W        = 8;
  localparam int unsigned RES_W       = 24;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StGap   = 3'd2,
    StWait  = 3'd3,
    StResp  = 3'd4,
    StAbort = 3'd5
  } state_e;

endpackage

// File: rtl/fun_rr_pick.sv
// Two-way round-robin pick: on a tie the requester that was not served last wins.
module fun_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/fun_arbiter.sv
// Arbitrates two requesters onto one shared multi-cycle function unit, with busy timeout abort.
module fun_arbiter
  import fun_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic [OP_W-1:0]  a0_i,
  input  logic [OP_W-1:0]  b0_i,
  input  logic [OP_W-1:0]  a1_i,
  input  logic [OP_W-1:0]  b1_i,
  output logic             ack0_o,
  output logic             ack1_o,
  output logic             done0_o,
  output logic             done1_o,
  output logic             err0_o,
  output logic             err1_o,
  output logic [RES_W-1:0] y0_o,
  output logic [RES_W-1:0] y1_o,
  output logic             owner_o,
  output logic             busy_o,
  output logic             fun_rst_o,
  output logic             fun_start_o,
  output logic [OP_W-1:0]  fun_a_o,
  output logic [OP_W-1:0]  fun_b_o,
  input  logic [RES_W-1:0] fun_y_i,
  input  logic             fun_busy_i
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic       ptr_q;
  logic       pick_winner;
  logic       pick_valid;

  fun_rr_pick u_pick (
    .req    ({req1_i, req0_i}),
    .last   (ptr_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  assign busy_o = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      ptr_q       <= 1'b1;
      owner_o     <= 1'b0;
      ack0_o      <= 1'b0;
      ack1_o      <= 1'b0;
      done0_o     <= 1'b0;
      done1_o     <= 1'b0;
      err0_o      <= 1'b0;
      err1_o      <= 1'b0;
      y0_o        <= '0;
      y1_o        <= '0;
      fun_rst_o   <= 1'b1;
      fun_start_o <= 1'b0;
      fun_a_o     <= '0;
      fun_b_o     <= '0;
    end else begin
      // All handshake outputs are single-cycle pulses.
      ack0_o      <= 1'b0;
      ack1_o      <= 1'b0;
      done0_o     <= 1'b0;
      done1_o     <= 1'b0;
      err0_o      <= 1'b0;
      err1_o      <= 1'b0;
      fun_rst_o   <= 1'b0;
      fun_start_o <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            owner_o     <= pick_winner;
            fun_a_o     <= pick_winner ? a1_i : a0_i;
            fun_b_o     <= pick_winner ? b1_i : b0_i;
            fun_start_o <= 1'b1;
            ack0_o      <= ~pick_winner;
            ack1_o      <= pick_winner;
            state_q     <= StIssue;
          end
        end
        StIssue: state_q <= StGap;
        StGap: begin
          cnt_q   <= 8'd0;
          state_q <= StWait;
        end
        StWait: begin
          if (!fun_busy_i) begin
            if (owner_o) begin
              y1_o    <= fun_y_i;
              done1_o <= 1'b1;
            end else begin
              y0_o    <= fun_y_i;
              done0_o <= 1'b1;
            end
            ptr_q   <= owner_o;
            state_q <= StResp;
          end else if (cnt_q + 8'd1 == TimeoutCnt) begin
            // This cycle completes TIMEOUT busy WAIT cycles: reset the unit and flag the owner.
            if (owner_o) begin
              y1_o    <= '0;
              done1_o <= 1'b1;
              err1_o  <= 1'b1;
            end else begin
              y0_o    <= '0;
              done0_o <= 1'b1;
              err0_o  <= 1'b1;
            end
            fun_rst_o <= 1'b1;
            ptr_q     <= owner_o;
            state_q   <= StAbort;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StResp:  state_q <= StIdle;
        StAbort: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fun_arbiter.sv
// Directed bench for fun_arbiter with a behavioural shared-unit model (busy for L cycles).
module tb_fun_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_i = 1'b0, req1_i = 1'b0;
  logic [7:0]  a0_i = '0, b0_i = '0, a1_i = '0, b1_i = '0;
  logic        ack0_o, ack1_o, done0_o, done1_o, err0_o, err1_o;
  logic [23:0] y0_o, y1_o;
  logic        owner_o, busy_o, fun_rst_o, fun_start_o;
  logic [7:0]  fun_a_o, fun_b_o;
  logic [23:0] fun_y_i;
  logic        fun_busy_i;

  int n_checks = 0;
  int n_errors = 0;

  fun_arbiter #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_i      (req0_i),
    .req1_i      (req1_i),
    .a0_i        (a0_i),
    .b0_i        (b0_i),
    .a1_i        (a1_i),
    .b1_i        (b1_i),
    .ack0_o      (ack0_o),
    .ack1_o      (ack1_o),
    .done0_o     (done0_o),
    .done1_o     (done1_o),
    .err0_o      (err0_o),
    .err1_o      (err1_o),
    .y0_o        (y0_o),
    .y1_o        (y1_o),
    .owner_o     (owner_o),
    .busy_o      (busy_o),
    .fun_rst_o   (fun_rst_o),
    .fun_start_o (fun_start_o),
    .fun_a_o     (fun_a_o),
    .fun_b_o     (fun_b_o),
    .fun_y_i     (fun_y_i),
    .fun_busy_i  (fun_busy_i)
  );

  always #5 clk = ~clk;

  // Shared-unit model.
  int unsigned m_lat = 3;
  bit          m_stuck = 1'b0;
  bit          m_fixed = 1'b0;
  logic [23:0] m_fixed_y = '0;
  int unsigned m_cnt = 0;
  logic [7:0]  m_a = '0, m_b = '0;

  function automatic logic [23:0] fmodel(input logic [7:0] a, input logic [7:0] b);
    return {a ^ b, a, b};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fun_busy_i <= 1'b0;
      fun_y_i    <= '0;
      m_cnt      <= 0;
    end else if (fun_rst_o) begin
      fun_busy_i <= 1'b0;
      m_cnt      <= 0;
    end else if (fun_start_o) begin
      fun_busy_i <= 1'b1;
      m_cnt      <= m_lat;
      m_a        <= fun_a_o;
      m_b        <= fun_b_o;
    end else if (fun_busy_i && !m_stuck) begin
      if (m_cnt == 1) begin
        fun_busy_i <= 1'b0;
        fun_y_i    <= m_fixed ? m_fixed_y : fmodel(m_a, m_b);
      end
      m_cnt <= m_cnt - 1;
    end
  end

  // Pulse monitors, sampled mid-cycle.
  int ack0_cnt = 0, ack1_cnt = 0, done0_cnt = 0, done1_cnt = 0;
  int err_cnt = 0, start_cnt = 0, frst_cnt = 0, overlap_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      ack0_cnt  += int'(ack0_o);
      ack1_cnt  += int'(ack1_o);
      done0_cnt += int'(done0_o);
      done1_cnt += int'(done1_o);
      err_cnt   += int'(err0_o) + int'(err1_o);
      start_cnt += int'(fun_start_o);
      frst_cnt  += int'(fun_rst_o);
      if ((ack0_o && ack1_o) || (done0_o && done1_o) || (err0_o && err1_o)) overlap_cnt++;
    end
  end

  task automatic clear_mon();
    ack0_cnt = 0; ack1_cnt = 0; done0_cnt = 0; done1_cnt = 0;
    err_cnt = 0; start_cnt = 0; frst_cnt = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request from idle: ack next cycle, done 2+W cycles after ack.
  task automatic do_op(input bit who, input logic [7:0] a, input logic [7:0] b,
                       input int unsigned lat, input bit stuck, input logic [23:0] exp_y,
                       input bit exp_err, input int unsigned exp_w);
    int n;
    m_lat = lat;
    m_stuck = stuck;
    if (who) begin a1_i = a; b1_i = b; req1_i = 1'b1; end
    else begin a0_i = a; b0_i = b; req0_i = 1'b1; end
    tick();
    check("op_ack", who ? ack1_o : ack0_o, 1);
    check("op_start", fun_start_o, 1);
    check("op_fun_a", fun_a_o, a);
    check("op_fun_b", fun_b_o, b);
    check("op_owner", owner_o, who);
    req0_i = 1'b0;
    req1_i = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(who ? done1_o : done0_o) && n < 400);
    check("op_latency", n, 2 + exp_w);
    check("op_y", who ? y1_o : y0_o, exp_y);
    check("op_err", who ? err1_o : err0_o, exp_err);
    check("op_fun_rst", fun_rst_o, exp_err);
    check("op_fun_a_hold", fun_a_o, a);
    tick();
    check("op_idle", busy_o, 0);
    m_stuck = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset values.
    #1 rst = 1'b1;
    #2;
    check("rst_fun_rst", fun_rst_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_owner", owner_o, 0);
    check("rst_y0", y0_o, 0);
    check("rst_start", fun_start_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rel_fun_rst_held", fun_rst_o, 1);
    tick();
    check("rel_fun_rst_drop", fun_rst_o, 0);

    // Both requesters held: grants alternate 0,1,0,1.
    m_lat = 3;
    a0_i = 8'h11; b0_i = 8'h22; a1_i = 8'h33; b1_i = 8'h44;
    req0_i = 1'b1; req1_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin tick(); n++; end while (!(ack0_o || ack1_o) && n < 50);
      check("rr_ack_seen", 32'(ack0_o | ack1_o), 1);
      check("rr_grant", ack1_o, 32'(k % 2));
      n = 0;
      do begin tick(); n++; end while (!(done0_o || done1_o) && n < 50);
      if (k == 3) begin req0_i = 1'b0; req1_i = 1'b0; end
      check("rr_y", (k % 2 == 1) ? y1_o : y0_o,
            (k % 2 == 1) ? fmodel(8'h33, 8'h44) : fmodel(8'h11, 8'h22));
    end
    tick();

    // Single request, fixed result, no activity on requester 1.
    clear_mon();
    m_fixed = 1'b1;
    m_fixed_y = 24'h000123;
    do_op(1'b0, 8'd3, 8'd4, 5, 1'b0, 24'h000123, 1'b0, 5);
    m_fixed = 1'b0;
    check("t1_ack0_cnt", ack0_cnt, 1);
    check("t1_start_cnt", start_cnt, 1);
    check("t1_done0_cnt", done0_cnt, 1);
    check("t1_ack1_cnt", ack1_cnt, 0);
    check("t1_done1_cnt", done1_cnt, 0);
    check("t1_y1_kept", y1_o, fmodel(8'h33, 8'h44));

    // Busy stuck: abort after 16 WAIT cycles, then a normal operation.
    clear_mon();
    do_op(1'b0, 8'd5, 8'd6, 3, 1'b1, 24'h0, 1'b1, 16);
    check("to_fun_rst_cnt", frst_cnt, 1);
    check("to_err_cnt", err_cnt, 1);
    do_op(1'b0, 8'd7, 8'd8, 3, 1'b0, fmodel(8'd7, 8'd8), 1'b0, 3);

    // req1 raised during req0's WAIT: one IDLE cycle, then ack1.
    m_lat = 4;
    a0_i = 8'd9; b0_i = 8'd10; req0_i = 1'b1;
    tick();
    check("ov_ack0", ack0_o, 1);
    req0_i = 1'b0;
    repeat (3) tick();
    a1_i = 8'h21; b1_i = 8'h43; req1_i = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!done0_o && n < 50);
    check("ov_done0", done0_o, 1);
    check("ov_y0", y0_o, fmodel(8'd9, 8'd10));
    tick();
    check("ov_idle", busy_o, 0);
    check("ov_no_ack1_yet", ack1_o, 0);
    tick();
    check("ov_ack1", ack1_o, 1);
    check("ov_fun_a", fun_a_o, 8'h21);
    req1_i = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!done1_o && n < 50);
    check("ov_y1", y1_o, fmodel(8'h21, 8'h43));
    tick();

    // Reset mid-WAIT: silent abort, then recovery.
    m_lat = 10;
    a0_i = 8'd1; b0_i = 8'd2; req0_i = 1'b1;
    tick();
    req0_i = 1'b0;
    repeat (3) tick();
    check("mr_busy_pre", busy_o, 1);
    clear_mon();
    rst = 1'b1;
    #1;
    check("mr_busy", busy_o, 0);
    check("mr_fun_rst", fun_rst_o, 1);
    check("mr_y0", y0_o, 0);
    check("mr_y1", y1_o, 0);
    check("mr_fun_a", fun_a_o, 0);
    check("mr_done0", done0_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("mr_fun_rst_drop", fun_rst_o, 0);
    check("mr_no_done", done0_cnt + done1_cnt + err_cnt, 0);
    do_op(1'b0, 8'hFF, 8'hFF, 2, 1'b0, fmodel(8'hFF, 8'hFF), 1'b0, 2);

    check("no_overlap", overlap_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
